// File: rtl/compute_store_buf_pkg.sv
// Shared types and sizing helpers for the compute_store_buf block and its shift register.
package compute_store_pkg;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_OFFER = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_NUM_BYTES = 16;
   localparam int unsigned BLK_W         = DEF_DATA_W * DEF_NUM_BYTES;

   // Counter width able to represent 0..n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/compute_store_buf_shift_reg.sv
// Block-wide shift register: serial fill at the MS end, parallel load, and a
// one-symbol pop in either direction with zero fill.
module store_shift_reg
   import compute_store_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned NUM_BYTES = DEF_NUM_BYTES
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr_i,
   input  logic                          load_serial_i,
   input  logic [DATA_W-1:0]             serial_i,
   input  logic                          load_parallel_i,
   input  logic [DATA_W*NUM_BYTES-1:0]   parallel_i,
   input  logic                          pop_i,
   input  logic                          reverse_i,
   output logic [DATA_W*NUM_BYTES-1:0]   data_o
);

   localparam int unsigned BW = DATA_W * NUM_BYTES;

   logic [BW-1:0] data_q, data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   always_comb begin
      data_d = data_q;
      if (clr_i) begin
         data_d = '0;
      end else if (load_parallel_i) begin
         data_d = parallel_i;
      end else if (load_serial_i) begin
         data_d = {serial_i, data_q[BW-1:DATA_W]};
      end else if (pop_i) begin
         if (reverse_i) begin
            data_d = {data_q[BW-DATA_W-1:0], {DATA_W{1'b0}}};
         end else begin
            data_d = {{DATA_W{1'b0}}, data_q[BW-1:DATA_W]};
         end
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/compute_store_buf.sv
// Byte-serial to block deserialiser / block to byte-serial serialiser around a block compute core.
// Optional macro COMPUTE_STORE_REVERSE_EN: drain MS symbol first instead of LS symbol first.
module compute_store_buf
   import compute_store_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned NUM_BYTES = DEF_NUM_BYTES,
   parameter int unsigned CNT_W     = cnt_width(NUM_BYTES)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          clr,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [DATA_W*NUM_BYTES-1:0]   blk_out,
   output logic                          blk_out_valid,
   input  logic                          blk_out_ready,
   input  logic [DATA_W*NUM_BYTES-1:0]   blk_in,
   input  logic                          blk_in_valid,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CNT_W-1:0]              count,
   output logic                          busy
);

   localparam int unsigned BW = DATA_W * NUM_BYTES;

`ifdef COMPUTE_STORE_REVERSE_EN
   localparam logic REVERSE = 1'b1;
`else
   localparam logic REVERSE = 1'b0;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [BW-1:0]    shreg;
   logic [DATA_W-1:0] head_sym;

   logic accept_in, take_blk, load_res, pop;

   // clr suppresses every coincident transfer so nothing leaks into the next block.
   assign accept_in = (state_q == S_FILL)  && in_valid      && !clr;
   assign take_blk  = (state_q == S_OFFER) && blk_out_ready && !clr;
   assign load_res  = (state_q == S_WAIT)  && blk_in_valid  && !clr;
   assign pop       = (state_q == S_DRAIN) && out_ready     && !clr;

   store_shift_reg #(
      .DATA_W    (DATA_W),
      .NUM_BYTES (NUM_BYTES)
   ) u_shreg (
      .clk             (clk),
      .rst_n           (reset_n),
      .clr_i           (clr),
      .load_serial_i   (accept_in),
      .serial_i        (in_data),
      .load_parallel_i (load_res),
      .parallel_i      (blk_in),
      .pop_i           (pop),
      .reverse_i       (REVERSE),
      .data_o          (shreg)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FILL;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FILL: begin
            if (accept_in && (count_q == CNT_W'(NUM_BYTES - 1))) begin
               state_d = S_OFFER;
            end
         end
         S_OFFER: begin
            if (take_blk) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (load_res) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && (count_q == CNT_W'(1))) begin
               state_d = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
      if (clr) begin
         state_d = S_FILL;
      end
   end

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (accept_in) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   assign head_sym = REVERSE ? shreg[BW-1 -: DATA_W] : shreg[DATA_W-1:0];

   always_comb begin
      in_ready      = (state_q == S_FILL);
      blk_out_valid = (state_q == S_OFFER);
      out_valid     = (state_q == S_DRAIN);
      out_data      = out_valid ? head_sym : '0;
      blk_out       = shreg;
      count         = count_q;
      busy          = (state_q != S_FILL) || (count_q != '0);
   end

endmodule

// File: tb/tb_compute_store_buf.sv
// Directed bench for compute_store_buf with NUM_BYTES=4, DATA_W=8.
module tb_compute_store_buf;

   logic        clk;
   logic        reset_n;
   logic        clr;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] blk_out;
   logic        blk_out_valid;
   logic        blk_out_ready;
   logic [31:0] blk_in;
   logic        blk_in_valid;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  count;
   logic        busy;

   int unsigned errors = 0;
   int unsigned checks = 0;

   compute_store_buf #(
      .DATA_W    (8),
      .NUM_BYTES (4)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .clr           (clr),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .blk_out       (blk_out),
      .blk_out_valid (blk_out_valid),
      .blk_out_ready (blk_out_ready),
      .blk_in        (blk_in),
      .blk_in_valid  (blk_in_valid),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .count         (count),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic feed(input logic [7:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
   endtask

   logic [7:0] exp_b [4];
   logic       rdy   [6];
   int unsigned idx;

   initial begin
      reset_n = 1'b0; clr = 1'b0; in_data = '0; in_valid = 1'b0;
      blk_out_ready = 1'b0; blk_in = '0; blk_in_valid = 1'b0; out_ready = 1'b0;
`ifdef COMPUTE_STORE_REVERSE_EN
      exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
`else
      exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
`endif
      rdy[0] = 1'b1; rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[3] = 1'b1; rdy[4] = 1'b1; rdy[5] = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_blk_out", blk_out, 32'h0);
      chk("rst_blk_out_valid", 32'(blk_out_valid), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      reset_n = 1'b1;

      // Fill 0x11..0x44
      feed(8'h11);
      feed(8'h22);
      feed(8'h33);
      chk("fill_count2", 32'(count), 32'd2);
      feed(8'h44);
      @(negedge clk);
      in_valid = 1'b0;
      chk("fill_blk_out", blk_out, 32'h44332211);
      chk("fill_blk_valid", 32'(blk_out_valid), 32'd1);
      chk("fill_in_ready", 32'(in_ready), 32'd0);
      chk("fill_count4", 32'(count), 32'd4);

      // Hold off the core for 5 cycles while pushing ignored input
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'hEE;
         @(negedge clk);
         chk("hold_blk_out", blk_out, 32'h44332211);
         chk("hold_count", 32'(count), 32'd4);
      end
      in_valid = 1'b0;
      chk("hold_blk_valid", 32'(blk_out_valid), 32'd1);

      blk_out_ready = 1'b1;
      @(negedge clk);
      blk_out_ready = 1'b0;
      chk("wait_blk_valid", 32'(blk_out_valid), 32'd0);
      chk("wait_out_valid", 32'(out_valid), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_count", 32'(count), 32'd4);

      blk_in       = 32'hA1B2C3D4;
      blk_in_valid = 1'b1;
      @(negedge clk);
      blk_in_valid = 1'b0;
      blk_in       = '0;

      // Drain with backpressure pattern 1,0,0,1,1,1
      idx = 0;
      for (int k = 0; k < 6; k++) begin
         chk("drain_out_valid", 32'(out_valid), 32'd1);
         chk("drain_out_data", 32'(out_data), 32'(exp_b[idx]));
         chk("drain_count", 32'(count), 32'(4 - idx));
         out_ready = rdy[k];
         @(negedge clk);
         if (rdy[k]) idx++;
      end
      out_ready = 1'b0;
      chk("post_drain_out_valid", 32'(out_valid), 32'd0);
      chk("post_drain_out_data", 32'(out_data), 32'h0);
      chk("post_drain_count", 32'(count), 32'd0);
      chk("post_drain_in_ready", 32'(in_ready), 32'd1);
      chk("post_drain_busy", 32'(busy), 32'd0);

      // clr after 2 symbols, coincident with a 3rd
      feed(8'h01);
      feed(8'h02);
      @(negedge clk);
      in_data = 8'h03;
      clr     = 1'b1;
      @(negedge clk);
      clr      = 1'b0;
      in_valid = 1'b0;
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_blk_out", blk_out, 32'h0);
      chk("clr_in_ready", 32'(in_ready), 32'd1);
      chk("clr_busy", 32'(busy), 32'd0);
      feed(8'h55);
      feed(8'h66);
      feed(8'h77);
      feed(8'h88);
      @(negedge clk);
      in_valid = 1'b0;
      chk("clean_blk_out", blk_out, 32'h88776655);
      chk("clean_blk_valid", 32'(blk_out_valid), 32'd1);

      // Reset mid-drain at count==2
      blk_out_ready = 1'b1;
      @(negedge clk);
      blk_out_ready = 1'b0;
      blk_in        = 32'h0A0B0C0D;
      blk_in_valid  = 1'b1;
      @(negedge clk);
      blk_in_valid = 1'b0;
      out_ready    = 1'b1;
      repeat (2) @(negedge clk);
      out_ready = 1'b0;
      chk("middrain_count", 32'(count), 32'd2);
      chk("middrain_out_valid", 32'(out_valid), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("areset_out_valid", 32'(out_valid), 32'd0);
      chk("areset_out_data", 32'(out_data), 32'h0);
      chk("areset_count", 32'(count), 32'd0);
      chk("areset_blk_out", blk_out, 32'h0);
      chk("areset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      chk("release_busy", 32'(busy), 32'd0);
      chk("release_out_valid", 32'(out_valid), 32'd0);

      // Spurious result pulse while filling
      blk_in       = 32'hFFFFFFFF;
      blk_in_valid = 1'b1;
      @(negedge clk);
      blk_in_valid = 1'b0;
      @(negedge clk);
      chk("spur_blk_out", blk_out, 32'h0);
      chk("spur_count", 32'(count), 32'd0);
      chk("spur_out_valid", 32'(out_valid), 32'd0);
      chk("spur_busy", 32'(busy), 32'd0);
      chk("spur_in_ready", 32'(in_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
